// File: rtl/kmeans_centroid_accum.sv
// Per-cluster coordinate sum / member-count accumulator with ordered drain on flush.
// Optional saturating arithmetic with io_out_ovf port: define KMEANS_ACC_SAT_EN.
module kmeans_centroid_accum #(
    parameter int unsigned K       = 10,
    parameter int unsigned DIMS    = 2,
    parameter int unsigned COORD_W = 32,
    parameter int unsigned SUM_W   = 48,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    io_in_valid,
    output logic                    io_in_ready,
    input  logic [31:0]             io_in_cluster,
    input  logic [DIMS*COORD_W-1:0] io_in_point,
    input  logic                    io_flush,
    output logic                    io_out_valid,
    input  logic                    io_out_ready,
    output logic [31:0]             io_out_cluster,
    output logic [DIMS*SUM_W-1:0]   io_out_sum,
    output logic [CNT_W-1:0]        io_out_count,
`ifdef KMEANS_ACC_SAT_EN
    output logic                    io_out_ovf,
`endif
    output logic                    io_done,
    output logic [15:0]             io_dropped
);

    localparam int unsigned IDX_W = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {ACCUM, DRAIN, DONE} stateT;

    stateT state, stateNext;

    logic signed [SUM_W-1:0] sumMem [K][DIMS];
    logic [CNT_W-1:0]        cntMem [K];
    logic signed [SUM_W-1:0] accSum [DIMS];
    logic [CNT_W-1:0]        accCnt;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        drainIdx;
    logic [IDX_W-1:0]        nextIdx;
    logic                    accept;
    logic                    inRange;
    logic                    hit;
    logic                    outFire;
    logic                    lastRec;
`ifdef KMEANS_ACC_SAT_EN
    localparam logic signed [SUM_W-1:0] SUM_MAX = {1'b0, {(SUM_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};
    logic [K-1:0]            ovfMem;
    logic                    accOvf;
`endif

    assign io_in_ready = (state == ACCUM);
    assign accept      = io_in_valid && io_in_ready;
    assign inRange     = io_in_cluster < K;
    assign hit         = accept && inRange;
    assign idx         = io_in_cluster[IDX_W-1:0];
    assign outFire     = io_out_valid && io_out_ready;
    assign lastRec     = drainIdx == IDX_W'(K - 1);
    assign nextIdx     = drainIdx + IDX_W'(1);

    // Updated totals for the addressed cluster; also feeds record 0 when a
    // sample lands in the same cycle as the flush.
    always_comb begin
        accCnt = cntMem[idx] + CNT_W'(1);
`ifdef KMEANS_ACC_SAT_EN
        accOvf = ovfMem[idx];
        if (cntMem[idx] == '1) begin
            accCnt = cntMem[idx];
            accOvf = 1'b1;
        end
`endif
        for (int unsigned d = 0; d < DIMS; d++) begin
            logic signed [COORD_W-1:0] coord;
            logic signed [SUM_W-1:0]   ext;
            coord     = io_in_point[d*COORD_W +: COORD_W];
            ext       = SUM_W'(coord);
            accSum[d] = sumMem[idx][d] + ext;
`ifdef KMEANS_ACC_SAT_EN
            if (sumMem[idx][d][SUM_W-1] == ext[SUM_W-1] &&
                accSum[d][SUM_W-1] != ext[SUM_W-1]) begin
                accSum[d] = ext[SUM_W-1] ? SUM_MIN : SUM_MAX;
                accOvf    = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ACCUM;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            ACCUM:   if (io_flush) stateNext = DRAIN;
            DRAIN:   if (outFire && lastRec) stateNext = DONE;
            DONE:    stateNext = ACCUM;
            default: stateNext = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < K; c++) begin
                cntMem[c] <= '0;
                for (int unsigned d = 0; d < DIMS; d++) sumMem[c][d] <= '0;
            end
`ifdef KMEANS_ACC_SAT_EN
            ovfMem     <= '0;
            io_out_ovf <= 1'b0;
`endif
            drainIdx       <= '0;
            io_out_valid   <= 1'b0;
            io_out_cluster <= '0;
            io_out_sum     <= '0;
            io_out_count   <= '0;
            io_done        <= 1'b0;
            io_dropped     <= '0;
        end else begin
            io_done <= 1'b0;
            case (state)
                ACCUM: begin
                    if (hit) begin
                        cntMem[idx] <= accCnt;
                        for (int unsigned d = 0; d < DIMS; d++) sumMem[idx][d] <= accSum[d];
`ifdef KMEANS_ACC_SAT_EN
                        ovfMem[idx] <= accOvf;
`endif
                    end
                    if (accept && !inRange && io_dropped != '1)
                        io_dropped <= io_dropped + 16'd1;
                    if (io_flush) begin
                        drainIdx       <= '0;
                        io_out_valid   <= 1'b1;
                        io_out_cluster <= '0;
                        if (hit && idx == '0) begin
                            io_out_count <= accCnt;
                            for (int unsigned d = 0; d < DIMS; d++)
                                io_out_sum[d*SUM_W +: SUM_W] <= accSum[d];
`ifdef KMEANS_ACC_SAT_EN
                            io_out_ovf <= accOvf;
`endif
                        end else begin
                            io_out_count <= cntMem[0];
                            for (int unsigned d = 0; d < DIMS; d++)
                                io_out_sum[d*SUM_W +: SUM_W] <= sumMem[0][d];
`ifdef KMEANS_ACC_SAT_EN
                            io_out_ovf <= ovfMem[0];
`endif
                        end
                    end
                end
                DRAIN: begin
                    if (outFire) begin
                        cntMem[drainIdx] <= '0;
                        for (int unsigned d = 0; d < DIMS; d++) sumMem[drainIdx][d] <= '0;
`ifdef KMEANS_ACC_SAT_EN
                        ovfMem[drainIdx] <= 1'b0;
`endif
                        if (lastRec) begin
                            io_out_valid <= 1'b0;
                            io_done      <= 1'b1;
                        end else begin
                            drainIdx       <= nextIdx;
                            io_out_cluster <= 32'(nextIdx);
                            io_out_count   <= cntMem[nextIdx];
                            for (int unsigned d = 0; d < DIMS; d++)
                                io_out_sum[d*SUM_W +: SUM_W] <= sumMem[nextIdx][d];
`ifdef KMEANS_ACC_SAT_EN
                            io_out_ovf <= ovfMem[nextIdx];
`endif
                        end
                    end
                end
                DONE: io_dropped <= '0;
                default: ;
            endcase
        end
    end

endmodule
